// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_width_e;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      RESP
   } lsu_state_e;

   // Width 11 is never legal; half and word accesses must be naturally aligned.
   function automatic logic lsu_illegal(input logic [1:0] width, input logic [1:0] offset);
      logic bad;
      case (mem_width_e'(width))
         BYTE:    bad = 1'b0;
         HALF:    bad = offset[0];
         WORD:    bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enable/data replication and
// load lane extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_st_width,
   input  logic [1:0]  i_st_offset,
   input  logic [31:0] i_st_wdata,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_wdata,
   input  logic [1:0]  i_ld_width,
   input  logic        i_ld_sign,
   input  logic [1:0]  i_ld_offset,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data
);

   logic [15:0] w_lane;

   always_comb begin
      o_st_be    = 4'b0000;
      o_st_wdata = i_st_wdata;
      case (mem_width_e'(i_st_width))
         BYTE: begin
            o_st_be    = 4'b0001 << i_st_offset;
            o_st_wdata = {4{i_st_wdata[7:0]}};
         end
         HALF: begin
            o_st_be    = 4'b0011 << i_st_offset;
            o_st_wdata = {2{i_st_wdata[15:0]}};
         end
         WORD:    o_st_be = 4'b1111;
         default: o_st_be = 4'b0000;
      endcase
   end

   // i_ld_sign = 1 selects zero extension (func3[2]).
   assign w_lane = 16'(i_ld_rdata >> {i_ld_offset, 3'b000});

   always_comb begin
      o_ld_data = i_ld_rdata;
      case (mem_width_e'(i_ld_width))
         BYTE:    o_ld_data = {{24{~i_ld_sign & w_lane[7]}}, w_lane[7:0]};
         HALF:    o_ld_data = {{16{~i_ld_sign & w_lane[15]}}, w_lane};
         default: o_ld_data = i_ld_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit. Define LSU_BUS_TIMEOUT_EN to abort
// bus waits after TIMEOUT_CYCLES cycles with an error response.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        mem_sign_i,
   input  logic [1:0]  mem_width_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("lsu: TIMEOUT_CYCLES must be at least 2");
   end

   lsu_state_e  r_state;
   lsu_state_e  w_state_next;
   logic        r_we;
   logic        r_sign;
   logic        r_err;
   logic [1:0]  r_width;
   logic [1:0]  r_offset;
   logic [3:0]  r_be;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        w_accept;
   logic        w_illegal;
   logic        w_timeout;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_data;

   assign w_accept  = req_valid_i & (r_state == IDLE) & (mem_read_i | mem_write_i);
   assign w_illegal = lsu_illegal(mem_width_i, addr_i[1:0]);

   lsu_align u_align (
      .i_st_width  (mem_width_i),
      .i_st_offset (addr_i[1:0]),
      .i_st_wdata  (wdata_i),
      .o_st_be     (w_st_be),
      .o_st_wdata  (w_st_wdata),
      .i_ld_width  (r_width),
      .i_ld_sign   (r_sign),
      .i_ld_offset (r_offset),
      .i_ld_rdata  (data_rdata_i),
      .o_ld_data   (w_ld_data)
   );

`ifdef LSU_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] r_cnt;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Restarts on every state change, so it times REQ and WAIT_RSP separately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_cnt <= '0;
      end else if ((r_state == REQ) || (r_state == WAIT_RSP)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      rsp_rdata_o  = '0;
      rsp_err_o    = 1'b0;
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_addr_o  = '0;
      data_wdata_o = '0;
      case (r_state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (w_accept) begin
               w_state_next = w_illegal ? RESP : REQ;
            end
         end
         REQ: begin
            data_req_o   = 1'b1;
            data_we_o    = r_we;
            data_be_o    = r_be;
            data_addr_o  = r_addr;
            data_wdata_o = r_wdata;
            if (data_gnt_i) begin
               w_state_next = WAIT_RSP;
            end else if (w_timeout) begin
               w_state_next = RESP;
            end
         end
         WAIT_RSP: begin
            if (data_rvalid_i || w_timeout) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid_o  = 1'b1;
            rsp_rdata_o  = r_rdata;
            rsp_err_o    = r_err;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we     <= 1'b0;
         r_sign   <= 1'b0;
         r_err    <= 1'b0;
         r_width  <= '0;
         r_offset <= '0;
         r_be     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else if (w_accept) begin
         r_we     <= mem_write_i;
         r_sign   <= mem_sign_i;
         r_err    <= w_illegal;
         r_width  <= mem_width_i;
         r_offset <= addr_i[1:0];
         r_be     <= w_st_be;
         r_addr   <= {addr_i[31:2], 2'b00};
         r_wdata  <= w_st_wdata;
         r_rdata  <= '0;
      end else if ((r_state == WAIT_RSP) && data_rvalid_i) begin
         r_err   <= data_err_i;
         r_rdata <= (r_we | data_err_i) ? '0 : w_ld_data;
      end else if (w_timeout && (((r_state == REQ) && !data_gnt_i) || (r_state == WAIT_RSP))) begin
         r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: per-cycle comparison against a transaction-level model.
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic        mem_sign_i = 1'b0;
   logic [1:0]  mem_width_i = 2'b00;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        data_req_o;
   logic        data_gnt_i = 1'b0;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic        data_err_i = 1'b0;

   lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .mem_sign_i    (mem_sign_i),
      .mem_width_i   (mem_width_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .data_req_o    (data_req_o),
      .data_gnt_i    (data_gnt_i),
      .data_we_o     (data_we_o),
      .data_be_o     (data_be_o),
      .data_addr_o   (data_addr_o),
      .data_wdata_o  (data_wdata_o),
      .data_rvalid_i (data_rvalid_i),
      .data_rdata_i  (data_rdata_i),
      .data_err_i    (data_err_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected outputs for the current cycle, maintained by the stimulus process.
   logic        chk_en = 1'b0;
   logic        exp_ready, exp_req, exp_we, exp_chk_wdata;
   logic        exp_rsp_valid, exp_err;
   logic [3:0]  exp_be;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;

   int          req_cycles = 0;
   int          rsp_pulses = 0;
   logic [31:0] cap_addr = '0, cap_wdata = '0, cap_rdata = '0;
   logic [3:0]  cap_be = '0;
   logic        cap_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic m_illegal(input logic [1:0] w, input logic [31:0] a);
      int off = int'(a % 4);
      if (w == 2'd3) return 1'b1;
      if (w == 2'd1 && (off % 2) != 0) return 1'b1;
      if (w == 2'd2 && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] w, input logic [31:0] a);
      int off = int'(a % 4);
      if (w == 2'd0) return 4'(1 << off);
      if (w == 2'd1) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
      if (w == 2'd0) return (d % 256) * 32'h0101_0101;
      if (w == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] w, input logic zext,
                                          input logic [31:0] a, input logic [31:0] d);
      logic [31:0] v;
      int off = int'(a % 4);
      v = d / (32'd1 << (8 * off));
      if (w == 2'd0) begin
         v = v % 256;
         if (!zext && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (w == 2'd1) begin
         v = v % 65536;
         if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk_i) begin
      if (data_req_o) begin
         req_cycles++;
         cap_addr  = data_addr_o;
         cap_be    = data_be_o;
         cap_wdata = data_wdata_o;
      end
      if (rsp_valid_o) begin
         rsp_pulses++;
         cap_rdata = rsp_rdata_o;
         cap_err   = rsp_err_o;
      end
      if (chk_en) begin
         check("req_ready", 32'(req_ready_o), 32'(exp_ready));
         check("data_req", 32'(data_req_o), 32'(exp_req));
         if (exp_req) begin
            check("data_addr", data_addr_o, exp_addr);
            check("data_be", 32'(data_be_o), 32'(exp_be));
            check("data_we", 32'(data_we_o), 32'(exp_we));
         end
         if (exp_req && exp_chk_wdata) check("data_wdata", data_wdata_o, exp_wdata);
         check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
         if (exp_rsp_valid) begin
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
            check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      exp_ready = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_chk_wdata = 1'b0;
      exp_rsp_valid = 1'b0; exp_err = 1'b0; exp_be = '0; exp_addr = '0;
      exp_wdata = '0; exp_rdata = '0;
   endtask

   task automatic set_busy();
      set_idle();
      exp_ready = 1'b0;
   endtask

   task automatic present(input logic rd, input logic wr, input logic sg, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] wd);
      req_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; mem_sign_i = sg;
      mem_width_i = w; addr_i = a; wdata_i = wd;
      set_idle();
      step();
      req_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
   endtask

   task automatic expect_req(input logic wr, input logic [1:0] w, input logic [31:0] a,
                             input logic [31:0] wd);
      set_busy();
      exp_req = 1'b1; exp_we = wr; exp_chk_wdata = wr;
      exp_addr = a & 32'hFFFF_FFFC; exp_be = m_be(w, a); exp_wdata = m_wdata(w, wd);
   endtask

   task automatic run_op(input logic rd, input logic wr, input logic sg, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd, input int gdly,
                         input int rdly, input logic [31:0] brd, input logic berr);
      present(rd, wr, sg, w, a, wd);
      if (!(rd | wr)) begin
         $display("op no-op addr=0x%08h", a);
         return;
      end
      if (m_illegal(w, a)) begin
         set_busy(); exp_rsp_valid = 1'b1; exp_err = 1'b1;
         step();
         set_idle();
         $display("op illegal rd=%0b wr=%0b width=%0d addr=0x%08h", rd, wr, w, a);
         return;
      end
      expect_req(wr, w, a, wd);
      for (int g = 0; g <= gdly; g++) begin
         data_gnt_i = (g == gdly);
         step();
      end
      data_gnt_i = 1'b0;
      set_busy();
      for (int r = 1; r <= rdly; r++) begin
         if (r == rdly) begin
            data_rvalid_i = 1'b1; data_rdata_i = brd; data_err_i = berr;
         end
         step();
      end
      data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
      set_busy();
      exp_rsp_valid = 1'b1; exp_err = berr;
      exp_rdata = (berr | wr) ? 32'h0 : m_load(w, sg, a, brd);
      step();
      set_idle();
      $display("op %s width=%0d zext=%0b addr=0x%08h gnt_dly=%0d rsp_dly=%0d bus_err=%0b",
               wr ? "store" : "load", w, sg, a, gdly, rdly, berr);
   endtask

   initial begin
      int p0, q0;
      set_idle();
      step();
      chk_en = 1'b1;
      step();
      rst_ni = 1'b1;
      step();

      // Store byte at lane 3
      p0 = rsp_pulses;
      run_op(1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, 1, 32'h0, 1'b0);
      check("t1_addr", cap_addr, 32'h0000_1000);
      check("t1_be", 32'(cap_be), 32'h8);
      check("t1_wdata", cap_wdata, 32'hDDDD_DDDD);
      check("t1_rdata", cap_rdata, 32'h0);
      check("t1_pulses", 32'(rsp_pulses - p0), 32'd1);

      // Half loads, sign- and zero-extended
      run_op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234, 1'b0);
      check("t2_signed", cap_rdata, 32'hFFFF_8001);
      run_op(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234, 1'b0);
      check("t2_zext", cap_rdata, 32'h0000_8001);

      // Misaligned word load: no bus activity, single error pulse
      p0 = rsp_pulses; q0 = req_cycles;
      run_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_3001, 32'h0, 0, 1, 32'h0, 1'b0);
      step();
      check("t3_req_cycles", 32'(req_cycles - q0), 32'd0);
      check("t3_pulses", 32'(rsp_pulses - p0), 32'd1);
      check("t3_err", 32'(cap_err), 32'd1);

      // Delayed grant then bus error
      q0 = req_cycles;
      run_op(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_4002, 32'h1234_5678, 3, 2, 32'h0, 1'b1);
      check("t4_req_cycles", 32'(req_cycles - q0), 32'd4);
      check("t4_be", 32'(cap_be), 32'hC);
      check("t4_err", 32'(cap_err), 32'd1);
      check("t4_rdata", cap_rdata, 32'h0);

      // Lane and extension sweep, plus illegal widths, no-op and read+write
      for (int off = 0; off < 4; off++) begin
         run_op(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_7000 + 32'(off), 32'h0, 0, 1, 32'h80FF_7F01, 1'b0);
         run_op(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_7000 + 32'(off), 32'h0, 1, 3, 32'h80FF_7F01, 1'b0);
      end
      run_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_8008, 32'h0, 0, 1, 32'hCAFE_BABE, 1'b0);
      check("word_load", cap_rdata, 32'hCAFE_BABE);
      run_op(1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_800C, 32'h0BAD_F00D, 1, 1, 32'h0, 1'b0);
      run_op(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_8000, 32'hAAAA_5A3C, 0, 1, 32'h0, 1'b0);
      check("half_store_wdata", cap_wdata, 32'h5A3C_5A3C);
      run_op(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_9000, 32'h0, 0, 1, 32'h0, 1'b0);
      run_op(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_9001, 32'h0, 0, 1, 32'h0, 1'b0);
      p0 = rsp_pulses; q0 = req_cycles;
      run_op(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_9100, 32'h0, 0, 1, 32'h0, 1'b0);
      step();
      check("noop_pulses", 32'(rsp_pulses - p0), 32'd0);
      check("noop_req", 32'(req_cycles - q0), 32'd0);
      run_op(1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_9202, 32'h0000_0077, 0, 2, 32'hFFFF_FFFF, 1'b0);
      check("rw_store_be", 32'(cap_be), 32'h4);
      check("rw_store_rdata", cap_rdata, 32'h0);

      // Asynchronous reset while waiting for rvalid
      present(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'h0);
      expect_req(1'b0, 2'b10, 32'h0000_5000, 32'h0);
      data_gnt_i = 1'b1;
      step();
      data_gnt_i = 1'b0;
      set_busy();
      step();
      p0 = rsp_pulses;
      rst_ni = 1'b0;
      set_idle();
      #1;
      check("rst_data_req", 32'(data_req_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_ready", 32'(req_ready_o), 32'd1);
      step();
      step();
      rst_ni = 1'b1;
      step();
      step();
      step();
      check("rst_no_pulse", 32'(rsp_pulses - p0), 32'd0);
      $display("op reset during WAIT_RSP");
      run_op(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_5002, 32'h0, 0, 1, 32'h1234_ABCD, 1'b0);
      check("post_rst_load", cap_rdata, 32'h0000_1234);

`ifdef LSU_BUS_TIMEOUT_EN
      // Grant never arrives: four request cycles, then an error response
      p0 = rsp_pulses; q0 = req_cycles;
      present(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_6000, 32'h0);
      expect_req(1'b0, 2'b10, 32'h0000_6000, 32'h0);
      repeat (4) step();
      set_busy();
      exp_rsp_valid = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
      step();
      set_idle();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
      step();
      data_rvalid_i = 1'b0; data_rdata_i = '0;
      step();
      step();
      check("to_req_cycles", 32'(req_cycles - q0), 32'd4);
      check("to_pulses", 32'(rsp_pulses - p0), 32'd1);
      check("to_err", 32'(cap_err), 32'd1);
      $display("op timeout with late rvalid");
`else
      // Without the timeout the request is held for as long as grant is withheld
      q0 = req_cycles;
      run_op(1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_6000, 32'h0, 20, 5, 32'h600D_600D, 1'b0);
      check("long_wait_req", 32'(req_cycles - q0), 32'd21);
      check("long_wait_rdata", cap_rdata, 32'h600D_600D);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the execute/memory stage.
- Consumes the decoder's memory-control outputs (mem_read, mem_write, mem_sign, mem_width) plus the ALU-computed address and rs2 store data.
- Drives a single-outstanding, word-addressed data-bus transaction.
- Returns sign/zero-extended load data to the register-file write mux.

Parameters:
- TIMEOUT_CYCLES, 16: cycles allowed in a bus wait state before abort. Used only with LSU_BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline presents a memory op
- req_ready_o  out  1  LSU accepts the op this cycle
- mem_read_i  in  1  load (decoder mem_read)
- mem_write_i  in  1  store (decoder mem_write)
- mem_sign_i  in  1  1 = zero-extend (func3[2]); loads only
- mem_width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- addr_i  in  32  byte address
- wdata_i  in  32  store data (rs2)
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned, illegal width, bus error, or timeout
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  bus response valid (loads and stores)
- data_rdata_i  in  32  bus read data
- data_err_i  in  1  bus error, qualified by rvalid

Behaviour:
- Reset (async, rst_ni low): state IDLE. All outputs 0 except req_ready_o. A reset mid-transaction drops it silently; no rsp pulse follows.
- req_ready_o is 1 only in IDLE. Acceptance = req_valid_i & req_ready_o & (mem_read_i | mem_write_i).
  - req_valid_i with neither read nor write: no-op, no response.
  - read & write together: treated as a store.
- On accept, register the op (address, lane, width, sign, we, formatted wdata, be).
- Illegal ops: mem_width_i == 11, half with addr[0] = 1, or word with addr[1:0] != 00.
  - Go to RESP.
  - rsp_err_o = 1, rsp_valid_o = 1 the next cycle.
  - No bus activity.
- States:
  - IDLE: on legal accept -> REQ.
  - REQ: data_req_o = 1, with addr/we/be/wdata held stable. On data_gnt_i -> WAIT_RSP. Request must not drop before grant.
  - WAIT_RSP: data_req_o = 0. On data_rvalid_i -> RESP, registering the formatted rdata and data_err_i. An rvalid in the same cycle as gnt is not legal; the bus guarantees rvalid ≥1 cycle after gnt.
  - RESP: rsp_valid_o = 1 for exactly one cycle -> IDLE. No backpressure; the pipeline must stall on busy.
- Minimum latency, legal op: accept at cycle 0, req+gnt at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
- Store formatting:
  - byte: be = 0001 << addr[1:0], wdata = {4{wdata_i[7:0]}}
  - half: be = 0011 << addr[1:0], wdata = {2{wdata_i[15:0]}}
  - word: be = 1111
- Load formatting: extract lane by registered addr[1:0] and width. Sign-extend from bit 7 or 15 when mem_sign = 0; zero-extend when 1. Word loads pass through unchanged.
- On bus error: rsp_rdata_o = 0, rsp_err_o = 1.
- Loads drive data_be_o per width, same as stores.

Optional Feature:
- LSU_BUS_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and on entry to WAIT_RSP, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 without gnt/rvalid respectively, go to RESP with rsp_err_o = 1 and drop data_req_o.
  - A late rvalid arriving in IDLE is ignored.
- Undefined: no counter; the LSU waits indefinitely.

Decomposition:
- Add to defs.svh: mem_width_e (BYTE=2'b00, HALF=2'b01, WORD=2'b10) and lsu_state_e (IDLE, REQ, WAIT_RSP, RESP).
- One combinational sub-module, lsu_align: store be/wdata replication plus load lane extraction and extension. The FSM stays in lsu.

Test Plan:
- Store byte, addr 0x1003, wdata 0xAABBCCDD -> data_addr 0x1000, be 1000, data_wdata 0xDDDDDDDD, we 1. rvalid -> rsp_valid pulse, rdata 0, err 0.
- Load half signed, addr 0x2002, bus rdata 0x8001_1234 -> rsp_rdata 0xFFFF8001. Same with mem_sign=1 -> 0x00008001.
- Load word addr 0x3001 -> rsp_err 1 next cycle, data_req never asserted, rsp_valid exactly 1 cycle.
- Gnt delayed 3 cycles -> data_req, addr, be held constant for 4 cycles. Then rvalid with data_err_i = 1 -> rsp_err 1, rdata 0.
- rst_ni pulled low in WAIT_RSP -> outputs 0 immediately. After release, req_ready 1, no rsp pulse, subsequent load completes normally.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, gnt never given -> data_req drops and rsp_err pulses after 4 REQ cycles. A late rvalid is ignored.
